cache_switch_ctrl: RTL and testbench

Sequences a hardware cache-bank switch when the OS signals a context switch. It stalls the CPU and waits for any in-flight cache miss to finish. It then walks every line of the outgoing bank, writing back and cleaning dirty lines, and finally retargets the cache to the incoming bank. It sits between the CSR/trap logic (which raises the switch request) and the banked data cache / memory interface inside cpu.

---
 rtl/cache_switch_ctrl_pkg.sv | 22 ++
 rtl/cache_switch_ctrl.sv | 148 ++++++++++++++
 tb/tb_cache_switch_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_switch_ctrl_pkg.sv
// Shared types for the cache bank-switch controller: FSM encoding and
// default-sized bank/line index types.
package cache_switch_ctrl_pkg;

    localparam int NUM_BANKS_DEF = 2;
    localparam int BANK_W_DEF    = 1;
    localparam int NUM_LINES_DEF = 8;
    localparam int IDX_W_DEF     = 3;
    localparam int CNT_W_DEF     = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAIN  = 3'd1,
        SCAN   = 3'd2,
        WB     = 3'd3,
        COMMIT = 3'd4
    } state_t;

    typedef logic [BANK_W_DEF-1:0] bank_t;
    typedef logic [IDX_W_DEF-1:0]  idx_t;

endpackage

// File: rtl/cache_switch_ctrl.sv
// Cache bank-switch sequencer: stalls the CPU, drains an in-flight miss,
// writes back and cleans every dirty line of the outgoing bank, then retargets.
module cache_switch_ctrl
    import cache_switch_ctrl_pkg::*;
#(
    parameter int NUM_BANKS = NUM_BANKS_DEF,
    parameter int BANK_W    = BANK_W_DEF,
    parameter int NUM_LINES = NUM_LINES_DEF,
    parameter int IDX_W     = IDX_W_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              switch_req,
    input  logic [BANK_W-1:0] switch_bank,
    input  logic              cache_busy,
    input  logic              line_dirty,
    input  logic              wb_done,
    output logic              stall_cpu,
    output logic              busy,
    output logic [BANK_W-1:0] active_bank,
    output logic [IDX_W-1:0]  scan_idx,
    output logic              wb_req,
    output logic              clean_en,
    output logic              switch_ack,
    output logic [CNT_W-1:0]  switch_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

    state_t            state_reg, state_next;
    logic [BANK_W-1:0] active_bank_reg, active_bank_next;
    logic [BANK_W-1:0] target_reg, target_next;
    logic [IDX_W-1:0]  scan_idx_reg, scan_idx_next;
    logic              cleaning_reg, cleaning_next;
    logic              ack_reg, ack_next;
    logic [CNT_W-1:0]  count_reg, count_next;

    // An out-of-range bank id matches no bank and degrades to an ack-only no-op.
    logic [NUM_BANKS-1:0] bank_hit;
    logic                 bank_valid;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank_hit
            assign bank_hit[gi] = (switch_bank == BANK_W'(gi));
        end
    endgenerate

    assign bank_valid = |bank_hit;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_reg       <= IDLE;
            active_bank_reg <= '0;
            target_reg      <= '0;
            scan_idx_reg    <= '0;
            cleaning_reg    <= 1'b0;
            ack_reg         <= 1'b0;
            count_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            active_bank_reg <= active_bank_next;
            target_reg      <= target_next;
            scan_idx_reg    <= scan_idx_next;
            cleaning_reg    <= cleaning_next;
            ack_reg         <= ack_next;
            count_reg       <= count_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        active_bank_next = active_bank_reg;
        target_next      = target_reg;
        scan_idx_next    = scan_idx_reg;
        cleaning_next    = cleaning_reg;
        ack_next         = 1'b0;
        count_next       = count_reg;

        case (state_reg)
            IDLE: begin
                if (switch_req) begin
                    if (!bank_valid || (switch_bank == active_bank_reg)) begin
                        ack_next = 1'b1;
                    end else begin
                        target_next   = switch_bank;
                        scan_idx_next = '0;
                        state_next    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                scan_idx_next = '0;
                if (!cache_busy) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (line_dirty) begin
                    cleaning_next = 1'b0;
                    state_next    = WB;
                end else if (scan_idx_reg == LAST_IDX) begin
                    state_next = COMMIT;
                end else begin
                    scan_idx_next = scan_idx_reg + IDX_W'(1);
                end
            end
            WB: begin
                // Two phases: wait for wb_done with wb_req high, then one clean cycle.
                if (cleaning_reg) begin
                    cleaning_next = 1'b0;
                    if (scan_idx_reg == LAST_IDX) begin
                        state_next = COMMIT;
                    end else begin
                        scan_idx_next = scan_idx_reg + IDX_W'(1);
                        state_next    = SCAN;
                    end
                end else if (wb_done) begin
                    cleaning_next = 1'b1;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Retarget and count on entry so COMMIT already presents the new bank with the ack.
        if ((state_next == COMMIT) && (state_reg != COMMIT)) begin
            active_bank_next = target_reg;
            count_next       = count_reg + CNT_W'(1);
            ack_next         = 1'b1;
        end
    end

    assign stall_cpu    = (state_reg != IDLE);
    assign busy         = (state_reg != IDLE);
    assign active_bank  = active_bank_reg;
    assign scan_idx     = scan_idx_reg;
    assign wb_req       = (state_reg == WB) && !cleaning_reg;
    assign clean_en     = (state_reg == WB) && cleaning_reg;
    assign switch_ack   = ack_reg;
    assign switch_count = count_reg;

endmodule

// File: tb/tb_cache_switch_ctrl.sv
// Directed bench for cache_switch_ctrl with a small reactive cache/memory model.
module tb_cache_switch_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        switch_req = 1'b0;
    logic [0:0]  switch_bank = 1'b0;
    logic        cache_busy = 1'b0;
    logic        line_dirty;
    logic        wb_done;
    logic        stall_cpu;
    logic        busy;
    logic [0:0]  active_bank;
    logic [2:0]  scan_idx;
    logic        wb_req;
    logic        clean_en;
    logic        switch_ack;
    logic [15:0] switch_count;

    cache_switch_ctrl dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .switch_req  (switch_req),
        .switch_bank (switch_bank),
        .cache_busy  (cache_busy),
        .line_dirty  (line_dirty),
        .wb_done     (wb_done),
        .stall_cpu   (stall_cpu),
        .busy        (busy),
        .active_bank (active_bank),
        .scan_idx    (scan_idx),
        .wb_req      (wb_req),
        .clean_en    (clean_en),
        .switch_ack  (switch_ack),
        .switch_count(switch_count)
    );

    always #5 CLK = ~CLK;

    // Cache model: dirty map of the outgoing bank. Memory model: wb_done in
    // the wb_lat-th consecutive cycle of wb_req.
    logic [7:0] dirty_mask = 8'h00;
    int         wb_lat = 3;
    int         wb_cnt = 0;

    assign line_dirty = dirty_mask[scan_idx];
    assign wb_done    = wb_req && (wb_cnt == wb_lat - 1);

    always @(posedge CLK) wb_cnt <= wb_req ? wb_cnt + 1 : 0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge CLK);
    endtask

    int         r_stall, r_ack_n, r_ack_at, r_clean_n, r_excl, r_drain_bad;
    logic [0:0] r_ack_bank;
    logic [7:0] r_clean_mask, r_wb_mask;

    // One switch transaction: req pulse, then per-cycle observation until idle after the ack.
    task automatic run_switch(input string name, input logic [0:0] b,
                              input int busy_cyc, input int extra_cyc);
        logic finished;
        r_stall = 0; r_ack_n = 0; r_ack_at = 0; r_clean_n = 0;
        r_excl = 0; r_drain_bad = 0; r_ack_bank = 1'b0;
        r_clean_mask = 8'h00; r_wb_mask = 8'h00;
        finished = 1'b0;
        switch_bank = b;
        switch_req  = 1'b1;
        cache_busy  = 1'b0;
        tick();
        switch_req = 1'b0;
        for (int c = 1; c <= 200 && !finished; c++) begin
            cache_busy = (c <= busy_cyc);
            switch_req = (c == extra_cyc);
            if (busy_cyc > 0 && c <= busy_cyc + 1 && (scan_idx != 3'd0 || wb_req))
                r_drain_bad++;
            if (stall_cpu) r_stall++;
            if (switch_ack) begin
                r_ack_n++;
                r_ack_at   = c;
                r_ack_bank = active_bank;
            end
            if (clean_en) begin
                r_clean_n++;
                r_clean_mask[scan_idx] = 1'b1;
            end
            if (wb_req) r_wb_mask[scan_idx] = 1'b1;
            if (int'(wb_req) + int'(clean_en) + int'(switch_ack) > 1) r_excl++;
            if (r_ack_n > 0 && !stall_cpu && c >= r_ack_at + 3) finished = 1'b1;
            if (!finished) tick();
        end
        switch_req = 1'b0;
        cache_busy = 1'b0;
        check({name, "_done"}, {31'd0, finished}, 32'd1);
        check({name, "_excl"}, r_excl, 0);
        $display("switch %s: bank=%0d stall=%0d acks=%0d ack_cycle=%0d wb_mask=%h clean_mask=%h count=%0d",
                 name, b, r_stall, r_ack_n, r_ack_at, r_wb_mask, r_clean_mask, switch_count);
    endtask

    initial begin
        logic found;

        // Reset state
        RESET = 1'b0;
        tick();
        tick();
        check("rst_stall", {31'd0, stall_cpu}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_bank", {31'd0, active_bank}, 0);
        check("rst_idx", {29'd0, scan_idx}, 0);
        check("rst_ack", {31'd0, switch_ack}, 0);
        check("rst_count", {16'd0, switch_count}, 0);
        RESET = 1'b1;
        tick();

        // Same bank: ack only, no stall
        run_switch("same", 1'b0, 0, 0);
        check("same_stall", r_stall, 0);
        check("same_acks", r_ack_n, 1);
        check("same_ack_at", r_ack_at, 1);
        check("same_count", {16'd0, switch_count}, 0);

        // Clean bank change: 1 DRAIN + 8 SCAN + 1 COMMIT
        dirty_mask = 8'h00;
        run_switch("clean", 1'b1, 0, 0);
        check("clean_stall", r_stall, 10);
        check("clean_ack_at", r_ack_at, 10);
        check("clean_ack_bank", {31'd0, r_ack_bank}, 1);
        check("clean_wb", {24'd0, r_wb_mask}, 0);
        check("clean_count", {16'd0, switch_count}, 1);

        // Lines 2 and 7 dirty, 3-cycle write-back: 10 + 2*(3+1)
        dirty_mask = 8'h84;
        wb_lat = 3;
        run_switch("dirty", 1'b0, 0, 0);
        check("dirty_stall", r_stall, 18);
        check("dirty_ack_at", r_ack_at, 18);
        check("dirty_wb_mask", {24'd0, r_wb_mask}, 32'h84);
        check("dirty_clean_mask", {24'd0, r_clean_mask}, 32'h84);
        check("dirty_clean_n", r_clean_n, 2);
        check("dirty_bank", {31'd0, active_bank}, 0);
        check("dirty_count", {16'd0, switch_count}, 2);

        // cache_busy for 4 cycles after the request: 4 extra DRAIN cycles
        dirty_mask = 8'h00;
        run_switch("drain", 1'b1, 4, 0);
        check("drain_stall", r_stall, 14);
        check("drain_ack_at", r_ack_at, 14);
        check("drain_idx_wb", r_drain_bad, 0);
        check("drain_wb", {24'd0, r_wb_mask}, 0);
        check("drain_count", {16'd0, switch_count}, 3);

        // Second request during SCAN is dropped
        run_switch("extra", 1'b0, 0, 5);
        check("extra_acks", r_ack_n, 1);
        check("extra_stall", r_stall, 10);
        check("extra_count", {16'd0, switch_count}, 4);

        // Reset while waiting on a write-back at line 5
        dirty_mask  = 8'h20;
        wb_lat      = 1000;
        switch_bank = 1'b1;
        switch_req  = 1'b1;
        tick();
        switch_req = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            if (wb_req && scan_idx == 3'd5) found = 1'b1;
            else tick();
        end
        check("rstwb_reach", {31'd0, found}, 1);
        RESET = 1'b0;
        tick();
        check("rstwb_wb_req", {31'd0, wb_req}, 0);
        check("rstwb_stall", {31'd0, stall_cpu}, 0);
        check("rstwb_busy", {31'd0, busy}, 0);
        check("rstwb_clean", {31'd0, clean_en}, 0);
        check("rstwb_bank", {31'd0, active_bank}, 0);
        check("rstwb_idx", {29'd0, scan_idx}, 0);
        check("rstwb_count", {16'd0, switch_count}, 0);
        RESET = 1'b1;
        tick();

        // Fresh switch after reset scans from line 0 (line 0 dirty)
        dirty_mask = 8'h01;
        wb_lat     = 3;
        run_switch("post", 1'b1, 0, 0);
        check("post_stall", r_stall, 14);
        check("post_clean_mask", {24'd0, r_clean_mask}, 1);
        check("post_ack_bank", {31'd0, r_ack_bank}, 1);
        check("post_count", {16'd0, switch_count}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
